// File: rtl/llr_frame_packer_if.sv
// Sample-in / frame-out handshake bundle for llr_frame_packer.
// slave is the packer's view; master is the producer/decoder side driving it.
interface llr_frame_packer_if #(
    parameter int Y_NBITS = 8,
    parameter int BPS     = 12,
    parameter int Z_NBITS = 8
);
    logic signed [Y_NBITS-1:0] y;
    logic                      y_valid;
    logic                      y_sof;
    logic                      y_ready;
    logic [BPS*Z_NBITS-1:0]    z;
    logic                      z_valid;
    logic                      z_ready;

    modport master (output y, y_valid, y_sof, z_ready,
                    input  y_ready, z, z_valid);
    modport slave  (input  y, y_valid, y_sof, z_ready,
                    output y_ready, z, z_valid);
endinterface

// File: rtl/llr_frame_packer.sv
// Scales/saturates serial channel samples to Z-format LLRs and packs BPS of them per frame.
// Optional LLR_SAT_COUNT_EN adds a 16-bit saturating count of clipped samples (sat_cnt).
module llr_lane #(
    parameter int Z_NBITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               xfer,
    input  logic [Z_NBITS-1:0] d,
    output logic [Z_NBITS-1:0] q
);
    logic [Z_NBITS-1:0] work;

    // xfer copies the pre-edge working value, so a same-edge write to lane 0 is safe
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            q    <= '0;
        end else begin
            if (we)   work <= d;
            if (xfer) q    <= work;
        end
    end
endmodule

module llr_frame_packer #(
    parameter int BPS       = 12,
    parameter int Z_IBITS   = 4,
    parameter int Z_FBITS   = 4,
    parameter int Z_NBITS   = Z_IBITS + Z_FBITS,
    parameter int Y_NBITS   = 8,
    parameter int Y_FBITS   = 5,
    parameter int LLR_SHIFT = 1
) (
    input  logic                clk,
    input  logic                rst,
    llr_frame_packer_if.slave   bus,
`ifdef LLR_SAT_COUNT_EN
    output logic [15:0]         sat_cnt,
`endif
    output logic                sof_err
);
    localparam int S  = Z_FBITS + LLR_SHIFT - Y_FBITS;
    localparam int IW = (BPS > 1) ? $clog2(BPS) : 1;
    localparam logic signed [31:0] ZMAX = (32'sd1 <<< (Z_NBITS-1)) - 32'sd1;
    localparam logic signed [31:0] ZMIN = -ZMAX;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                          state, state_n;
    logic                            pend, pend_n;
    logic                            zv, zv_n;
    logic [IW-1:0]                   idx, idx_n, widx;
    logic                            y_ready, acc, last, xfer;
    logic signed [31:0]              yx, scaled;
    logic [Z_NBITS-1:0]              llr;
    logic                            sat;
    logic [BPS-1:0][Z_NBITS-1:0]     zl;

    // full-width scale, then symmetric clip so the most-negative code never appears
    assign yx = {{(32-Y_NBITS){bus.y[Y_NBITS-1]}}, bus.y};

    generate
        if (S >= 0) begin : g_shl
            assign scaled = yx <<< S;
        end else begin : g_shr
            assign scaled = yx >>> (-S);
        end
    endgenerate

    always_comb begin
        sat = 1'b0;
        llr = scaled[Z_NBITS-1:0];
        if (scaled > ZMAX) begin
            sat = 1'b1;
            llr = ZMAX[Z_NBITS-1:0];
        end else if (scaled < ZMIN) begin
            sat = 1'b1;
            llr = ZMIN[Z_NBITS-1:0];
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = 1'b0;
        xfer    = 1'b0;
        zv_n    = zv;
        idx_n   = idx;
        y_ready = (state == FILL);
        acc     = bus.y_valid && y_ready;
        widx    = bus.y_sof ? '0 : idx;
        last    = (widx == IW'(BPS-1));

        if (acc) idx_n = last ? '0 : widx + 1'b1;

        case (state)
            FILL: xfer = pend;
            HOLD: begin
                xfer = zv && bus.z_ready;
                if (xfer) state_n = FILL;
            end
            default: state_n = FILL;
        endcase

        if (xfer)                    zv_n = 1'b1;
        else if (zv && bus.z_ready)  zv_n = 1'b0;

        // completed frame moves out next edge only if the output will be free then
        if (acc && last) begin
            if (zv_n) state_n = HOLD;
            else      pend_n  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            pend    <= 1'b0;
            zv      <= 1'b0;
            idx     <= '0;
            sof_err <= 1'b0;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            zv      <= zv_n;
            idx     <= idx_n;
            sof_err <= acc && bus.y_sof && (idx != '0);
        end
    end

`ifdef LLR_SAT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)                           sat_cnt <= '0;
        else if (acc && sat && ~&sat_cnt)  sat_cnt <= sat_cnt + 16'd1;
    end
`endif

    generate
        for (genvar i = 0; i < BPS; i++) begin : g_lane
            llr_lane #(.Z_NBITS(Z_NBITS)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .we   (acc && (widx == IW'(i))),
                .xfer (xfer),
                .d    (llr),
                .q    (zl[i])
            );
        end
    endgenerate

    assign bus.z       = zl;
    assign bus.z_valid = zv;
    assign bus.y_ready = y_ready;
endmodule

// File: doc/llr_frame_packer.md
Name: llr_frame_packer

Overview:
- Front end of the LDPC decoder datapath, and the inverse of the hard-decision estimator at the decoder output.
- Accepts a serial stream of signed channel samples with a valid/ready handshake. Scales and saturates each sample to an LLR in Z format (Q Z_IBITS.Z_FBITS, two's complement). Packs BPS LLRs into one z frame.
- Presents each frame on a valid/ready output to the decoder core.
- Sign convention matches the estimator: positive LLR means bit 0, negative means bit 1.

Parameters:
- BPS, 12, LLRs per frame (lanes).
- Z_IBITS, 4, LLR integer bits.
- Z_FBITS, 4, LLR fraction bits.
- Z_NBITS, Z_IBITS+Z_FBITS, LLR width.
- Y_NBITS, 8, channel sample width (signed).
- Y_FBITS, 5, channel sample fraction bits.
- LLR_SHIFT, 1, log2 of the channel-reliability gain (2/sigma^2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- y  in  Y_NBITS  signed channel sample.
- y_valid  in  1  sample valid.
- y_sof  in  1  sample is lane 0 of a new frame; qualified by y_valid.
- y_ready  out  1  sample accepted when y_valid && y_ready.
- z  out  BPS*Z_NBITS  packed frame; lane i at z[Z_NBITS*(i+1)-1 : Z_NBITS*i].
- z_valid  out  1  frame valid.
- z_ready  in  1  decoder accepts frame.
- sof_err  out  1  one-cycle pulse: partial frame discarded by y_sof.

Behaviour:
- Reset (clk edge with rst=1):
  - z_valid=0, z=0, sof_err=0, y_ready=1.
  - Lane index=0, working buffer empty, state FILL.
  - Reset mid-frame discards the partial frame and any held or output frame.
- Scaling:
  - S = Z_FBITS + LLR_SHIFT - Y_FBITS.
  - S>=0: value = y << S.
  - S<0: value = arithmetic y >> -S (floor).
  - Compute at full width, then saturate symmetrically to [-(2^(Z_NBITS-1)-1), +(2^(Z_NBITS-1)-1)]. The most-negative code is never produced.
- Lane fill:
  - Each accepted sample is written to working lane idx; idx increments.
  - Accepted sample with y_sof=1 is written to lane 0 and sets idx=1.
  - If idx was nonzero at that point, the old partial frame is dropped and sof_err pulses in the next cycle.
  - y_sof on a sample arriving at idx=0 is legal, with no error.
  - Acceptance at idx=BPS-1 (without sof) completes the working frame; idx wraps to 0.
- Transfer from working buffer to output register:
  - Happens when the working frame is complete and the output is empty (z_valid=0) or being consumed this cycle (z_valid && z_ready).
  - z_valid rises the cycle after the last sample is accepted.
  - Latency: last sample accepted at edge N gives z_valid=1 after edge N+1 when the output is free.
- States:
  - FILL: y_ready=1.
    - Frame completes and transfer is possible → stays FILL; z_valid=1 next cycle.
    - Frame completes and output is occupied and not consumed → HOLD.
  - HOLD: y_ready=0; working frame is held.
    - On z_valid && z_ready → working frame moves to output the same edge; z_valid stays 1; return to FILL.
- Output:
  - z is stable while z_valid=1 and z_ready=0.
  - z_valid drops after consumption only when no new frame is transferred in that cycle.
  - Back-to-back: with z_ready=1 constantly and one sample per cycle, throughput is one frame per BPS cycles and y_ready never drops.
- y_sof received while in HOLD is not accepted, because y_ready=0. It is honoured when accepted later.

Optional Feature:
- Macro LLR_SAT_COUNT_EN.
- Defined:
  - Adds output sat_cnt (16 bits): counts accepted samples whose LLR was clipped.
  - Saturates at 16'hFFFF, no wrap.
  - Reset to 0 by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 12 samples y=0x20 (+1.0) with y_sof on the first, z_ready=1 → one cycle after the 12th accept, z_valid=1 and every lane=0x20 (+2.0 LLR); z_valid=0 the following cycle.
- Saturation, LLR_SHIFT=2 (S=1):
  - y=100 → lane 0x7F.
  - y=-100 → 0x81.
  - y=-128 → 0x81.
  - y=-3 → 0xFA.
  - With LLR_SAT_COUNT_EN: sat_cnt=3 after the three clipped samples.
- Lane order: samples 1..12 → lane i holds i+1 (scaled), and lane 0 sits at z[7:0].
- Backpressure: z_ready=0 with 24 samples offered →
  - First frame is output and held.
  - Second frame fills, then y_ready=0 (HOLD).
  - Raising z_ready for 1 cycle → second frame appears next cycle and y_ready=1.
- Resync: y_sof asserted at idx=5 → sof_err pulses once; the frame output is the 12 samples starting at the sof sample.
- Mid-frame rst at idx=7 with a frame pending in output → z_valid=0, y_ready=1; the next 12 samples form a clean frame.
